mcs8_bus_arb: RTL and testbench

- Memory/IO bus arbiter and wait-state sequencer for the MCS8 core.
- Shares one external 8-bit-data, 14-bit-address bus between two requesters: the CPU bus-cycle logic and a DMA engine.
- Generates the CPU READY (wait) handshake that the CPU state machine samples in T2/WAIT.
- Inserts a programmable number of wait states on every access.

---
 rtl/mcs8_bus_arb.sv | 100 ++++++++++
 tb/tb_mcs8_bus_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mcs8_bus_arb.sv
// mcs8_bus_arb: CPU/DMA bus arbiter with wait-state sequencing; MCS8_ARB_LOCK_EN adds a DMA bus lock.
module mcs8_bus_arb #(
    parameter int ADDR_W   = 14,
    parameter int WAIT_CYC = 1
) (
    input  logic              CLK1_I,
    input  logic              nRST_I,
    input  logic              CPU_REQ_I,
    input  logic              CPU_WR_I,
    input  logic              CPU_IO_I,
    input  logic [ADDR_W-1:0] CPU_ADDR_I,
    input  logic [7:0]        CPU_WDATA_I,
    output logic              CPU_READY_O,
    output logic [7:0]        CPU_RDATA_O,
    input  logic              DMA_REQ_I,
    input  logic              DMA_WR_I,
    input  logic [ADDR_W-1:0] DMA_ADDR_I,
    input  logic [7:0]        DMA_WDATA_I,
`ifdef MCS8_ARB_LOCK_EN
    input  logic              DMA_LOCK_I,
`endif
    output logic              DMA_GNT_O,
    output logic              DMA_ACK_O,
    output logic [7:0]        DMA_RDATA_O,
    output logic [ADDR_W-1:0] MEM_ADDR_O,
    output logic [7:0]        MEM_WDATA_O,
    input  logic [7:0]        MEM_RDATA_I,
    output logic              MEM_CS_O,
    output logic              MEM_WE_O,
    output logic              MEM_IO_O
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;
    logic [1:0] r_state;
    logic [3:0] r_cnt;
    logic       r_last_dma;
    logic       r_own_dma;
    logic       w_lock;
    logic       w_dma_win;
`ifdef MCS8_ARB_LOCK_EN
    assign w_lock = DMA_LOCK_I;
`else
    assign w_lock = 1'b0;
`endif
    // DMA wins when alone, when the CPU owned the bus last, or when it holds the lock
    assign w_dma_win = DMA_REQ_I & (~CPU_REQ_I | ~r_last_dma | w_lock);
    always_ff @(posedge CLK1_I) begin
        if (!nRST_I) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_last_dma  <= 1'b1;
            r_own_dma   <= 1'b0;
            CPU_READY_O <= 1'b0;
            CPU_RDATA_O <= 8'd0;
            DMA_GNT_O   <= 1'b0;
            DMA_ACK_O   <= 1'b0;
            DMA_RDATA_O <= 8'd0;
            MEM_ADDR_O  <= '0;
            MEM_WDATA_O <= 8'd0;
            MEM_CS_O    <= 1'b0;
            MEM_WE_O    <= 1'b0;
            MEM_IO_O    <= 1'b0;
        end else begin
            CPU_READY_O <= 1'b0;
            DMA_ACK_O   <= 1'b0;
            case (r_state)
                S_IDLE: if (CPU_REQ_I || DMA_REQ_I) begin
                    r_state     <= S_ACCESS;
                    r_cnt       <= 4'(WAIT_CYC);
                    r_own_dma   <= w_dma_win;
                    MEM_ADDR_O  <= w_dma_win ? DMA_ADDR_I : CPU_ADDR_I;
                    MEM_WDATA_O <= w_dma_win ? DMA_WDATA_I : CPU_WDATA_I;
                    MEM_WE_O    <= w_dma_win ? DMA_WR_I : CPU_WR_I;
                    MEM_IO_O    <= ~w_dma_win & CPU_IO_I;
                    MEM_CS_O    <= 1'b1;
                    DMA_GNT_O   <= w_dma_win;
                end
                S_ACCESS: if (r_cnt == 4'd0) begin
                    r_state     <= S_DONE;
                    MEM_CS_O    <= 1'b0;
                    MEM_WE_O    <= 1'b0;
                    MEM_IO_O    <= 1'b0;
                    DMA_GNT_O   <= 1'b0;
                    CPU_READY_O <= ~r_own_dma;
                    DMA_ACK_O   <= r_own_dma;
                    CPU_RDATA_O <= (!MEM_WE_O && !r_own_dma) ? MEM_RDATA_I : CPU_RDATA_O;
                    DMA_RDATA_O <= (!MEM_WE_O && r_own_dma) ? MEM_RDATA_I : DMA_RDATA_O;
                end else begin
                    r_cnt <= r_cnt - 4'd1;
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_last_dma <= r_own_dma;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mcs8_bus_arb.sv
// tb_mcs8_bus_arb: directed literal checks plus random traffic against a transaction-level model.
module tb_mcs8_bus_arb;
    localparam int AW = 14;
    localparam int W  = 1;
    logic          CLK1_I = 1'b0;
    logic          nRST_I = 1'b0;
    logic          CPU_REQ_I = 1'b0, CPU_WR_I = 1'b0, CPU_IO_I = 1'b0;
    logic [AW-1:0] CPU_ADDR_I = '0;
    logic [7:0]    CPU_WDATA_I = 8'd0;
    logic          CPU_READY_O;
    logic [7:0]    CPU_RDATA_O;
    logic          DMA_REQ_I = 1'b0, DMA_WR_I = 1'b0;
    logic [AW-1:0] DMA_ADDR_I = '0;
    logic [7:0]    DMA_WDATA_I = 8'd0;
    logic          DMA_LOCK_I = 1'b0;
    logic          DMA_GNT_O, DMA_ACK_O;
    logic [7:0]    DMA_RDATA_O;
    logic [AW-1:0] MEM_ADDR_O;
    logic [7:0]    MEM_WDATA_O;
    logic [7:0]    MEM_RDATA_I = 8'd0;
    logic          MEM_CS_O, MEM_WE_O, MEM_IO_O;

    mcs8_bus_arb #(.ADDR_W(AW), .WAIT_CYC(W)) dut (
        .CLK1_I(CLK1_I), .nRST_I(nRST_I),
        .CPU_REQ_I(CPU_REQ_I), .CPU_WR_I(CPU_WR_I), .CPU_IO_I(CPU_IO_I),
        .CPU_ADDR_I(CPU_ADDR_I), .CPU_WDATA_I(CPU_WDATA_I),
        .CPU_READY_O(CPU_READY_O), .CPU_RDATA_O(CPU_RDATA_O),
        .DMA_REQ_I(DMA_REQ_I), .DMA_WR_I(DMA_WR_I), .DMA_ADDR_I(DMA_ADDR_I),
        .DMA_WDATA_I(DMA_WDATA_I),
`ifdef MCS8_ARB_LOCK_EN
        .DMA_LOCK_I(DMA_LOCK_I),
`endif
        .DMA_GNT_O(DMA_GNT_O), .DMA_ACK_O(DMA_ACK_O), .DMA_RDATA_O(DMA_RDATA_O),
        .MEM_ADDR_O(MEM_ADDR_O), .MEM_WDATA_O(MEM_WDATA_O), .MEM_RDATA_I(MEM_RDATA_I),
        .MEM_CS_O(MEM_CS_O), .MEM_WE_O(MEM_WE_O), .MEM_IO_O(MEM_IO_O)
    );

    always #5 CLK1_I = ~CLK1_I;

    int n_vec = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge CLK1_I);
    endtask

    // Transaction model: m_t counts cycles since the grant edge, -1 when the bus is free
    int            m_t = -1;
    logic          m_last_dma = 1'b1, m_dma = 1'b0, m_wr = 1'b0, m_io = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [7:0]    m_wd = 8'd0, m_crd = 8'd0, m_drd = 8'd0;

    always @(posedge CLK1_I) begin
        logic lk;
`ifdef MCS8_ARB_LOCK_EN
        lk = DMA_LOCK_I;
`else
        lk = 1'b0;
`endif
        if (!nRST_I) begin
            m_t = -1; m_last_dma = 1'b1; m_dma = 1'b0; m_wr = 1'b0; m_io = 1'b0;
            m_addr = '0; m_wd = 8'd0; m_crd = 8'd0; m_drd = 8'd0;
        end else if (m_t < 0) begin
            if (CPU_REQ_I || DMA_REQ_I) begin
                if (CPU_REQ_I && DMA_REQ_I) m_dma = !m_last_dma || lk;
                else m_dma = DMA_REQ_I;
                m_addr = m_dma ? DMA_ADDR_I : CPU_ADDR_I;
                m_wd   = m_dma ? DMA_WDATA_I : CPU_WDATA_I;
                m_wr   = m_dma ? DMA_WR_I : CPU_WR_I;
                m_io   = m_dma ? 1'b0 : CPU_IO_I;
                m_t    = 0;
            end
        end else begin
            m_t++;
            if (m_t == W + 1 && !m_wr) begin
                if (m_dma) m_drd = MEM_RDATA_I;
                else m_crd = MEM_RDATA_I;
            end
            if (m_t == W + 2) begin
                m_last_dma = m_dma;
                m_t = -1;
            end
        end
    end

    always @(negedge CLK1_I) if (chk_en) begin
        logic cs, pulse;
        cs    = m_t >= 0 && m_t <= W;
        pulse = m_t == W + 1;
        chk("cs", MEM_CS_O, cs);
        chk("we", MEM_WE_O, cs & m_wr);
        chk("io", MEM_IO_O, cs & m_io);
        chk("gnt", DMA_GNT_O, cs & m_dma);
        chk("ready", CPU_READY_O, pulse & !m_dma);
        chk("ack", DMA_ACK_O, pulse & m_dma);
        chk("addr", 32'(MEM_ADDR_O), 32'(m_addr));
        chk("wdata", 32'(MEM_WDATA_O), 32'(m_wd));
        chk("cpu_rdata", 32'(CPU_RDATA_O), 32'(m_crd));
        chk("dma_rdata", 32'(DMA_RDATA_O), 32'(m_drd));
    end

    task automatic do_reset();
        nRST_I = 1'b0; CPU_REQ_I = 1'b0; DMA_REQ_I = 1'b0; DMA_LOCK_I = 1'b0;
        repeat (2) cyc();
        nRST_I = 1'b1;
        cyc();
    endtask

    task automatic alt_run(string nm, logic [3:0] exp_seq);
        int np = 0;
        logic [3:0] seq = 4'd0;
        CPU_REQ_I = 1'b1; CPU_WR_I = 1'b0; CPU_IO_I = 1'b0;
        DMA_REQ_I = 1'b1; DMA_WR_I = 1'b0;
        for (int i = 0; i < 40 && np < 4; i++) begin
            cyc();
            if (CPU_READY_O || DMA_ACK_O) begin
                chk({nm, "_overlap"}, CPU_READY_O & DMA_ACK_O, 1'b0);
                seq[np] = DMA_ACK_O;
                np++;
            end
        end
        chk({nm, "_count"}, np, 4);
        chk({nm, "_order"}, seq, exp_seq);
        CPU_REQ_I = 1'b0; DMA_REQ_I = 1'b0;
    endtask

    initial begin
        repeat (2) cyc();
        chk_en = 1'b1;
        chk("rst_cs", MEM_CS_O, 1'b0);
        chk("rst_ready", CPU_READY_O, 1'b0);
        chk("rst_ack", DMA_ACK_O, 1'b0);
        chk("rst_gnt", DMA_GNT_O, 1'b0);
        chk("rst_addr", 32'(MEM_ADDR_O), 32'd0);
        chk("rst_rdata", 32'(CPU_RDATA_O), 32'd0);
        nRST_I = 1'b1;
        repeat (2) cyc();
        chk("idle_cs", MEM_CS_O, 1'b0);
        // CPU read of 0x0123 returning 0x5A
        CPU_REQ_I = 1'b1; CPU_WR_I = 1'b0; CPU_IO_I = 1'b0;
        CPU_ADDR_I = 14'h0123; MEM_RDATA_I = 8'h5A;
        cyc();
        chk("rd_cs1", MEM_CS_O, 1'b1);
        chk("rd_addr", 32'(MEM_ADDR_O), 32'h0123);
        cyc();
        chk("rd_cs2", MEM_CS_O, 1'b1);
        chk("rd_ready_early", CPU_READY_O, 1'b0);
        cyc();
        chk("rd_ready", CPU_READY_O, 1'b1);
        chk("rd_data", 32'(CPU_RDATA_O), 32'h5A);
        chk("rd_cs_off", MEM_CS_O, 1'b0);
        CPU_REQ_I = 1'b0;
        cyc();
        chk("rd_ready_once", CPU_READY_O, 1'b0);
        // DMA write of 0xA5 to 0x3FFF
        DMA_REQ_I = 1'b1; DMA_WR_I = 1'b1; DMA_ADDR_I = 14'h3FFF; DMA_WDATA_I = 8'hA5;
        repeat (2) begin
            cyc();
            chk("dw_gnt", DMA_GNT_O, 1'b1);
            chk("dw_we", MEM_WE_O, 1'b1);
            chk("dw_wdata", 32'(MEM_WDATA_O), 32'hA5);
            chk("dw_addr", 32'(MEM_ADDR_O), 32'h3FFF);
        end
        cyc();
        chk("dw_ack", DMA_ACK_O, 1'b1);
        chk("dw_no_ready", CPU_READY_O, 1'b0);
        chk("dw_rdata_kept", 32'(DMA_RDATA_O), 32'h0);
        DMA_REQ_I = 1'b0;
        cyc();
        // IO write
        CPU_REQ_I = 1'b1; CPU_WR_I = 1'b1; CPU_IO_I = 1'b1;
        cyc();
        chk("io_on", MEM_IO_O, 1'b1);
        repeat (2) cyc();
        chk("io_off", MEM_IO_O, 1'b0);
        chk("io_ready", CPU_READY_O, 1'b1);
        CPU_REQ_I = 1'b0; CPU_IO_I = 1'b0;
        cyc();
        // Reset during the first ACCESS cycle of a DMA write
        DMA_REQ_I = 1'b1; DMA_WR_I = 1'b1;
        cyc();
        chk("mr_cs_on", MEM_CS_O & MEM_WE_O & DMA_GNT_O, 1'b1);
        nRST_I = 1'b0;
        cyc();
        chk("mr_cs", MEM_CS_O, 1'b0);
        chk("mr_we", MEM_WE_O, 1'b0);
        chk("mr_gnt", DMA_GNT_O, 1'b0);
        DMA_REQ_I = 1'b0; nRST_I = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("mr_no_pulse", CPU_READY_O | DMA_ACK_O, 1'b0);
        end
        do_reset();
        alt_run("alt", 4'b1010);
`ifdef MCS8_ARB_LOCK_EN
        do_reset();
        DMA_LOCK_I = 1'b1;
        alt_run("lock", 4'b1111);
        DMA_LOCK_I = 1'b0;
`endif
        for (int i = 0; i < 4000; i++) begin
            cyc();
            MEM_RDATA_I = 8'($urandom);
            DMA_LOCK_I  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 400) == 0) begin
                nRST_I = 1'b0; CPU_REQ_I = 1'b0; DMA_REQ_I = 1'b0;
                continue;
            end
            nRST_I = 1'b1;
            if (CPU_READY_O || $urandom_range(0, 40) == 0) CPU_REQ_I = 1'b0;
            else if (!CPU_REQ_I) CPU_REQ_I = ($urandom_range(0, 2) == 0);
            if (DMA_ACK_O || $urandom_range(0, 40) == 0) DMA_REQ_I = 1'b0;
            else if (!DMA_REQ_I) DMA_REQ_I = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) begin
                CPU_WR_I = 1'($urandom); CPU_IO_I = 1'($urandom);
                CPU_ADDR_I = AW'($urandom); CPU_WDATA_I = 8'($urandom);
            end
            if ($urandom_range(0, 1) == 0) begin
                DMA_WR_I = 1'($urandom);
                DMA_ADDR_I = AW'($urandom); DMA_WDATA_I = 8'($urandom);
            end
        end
        cyc();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
